// File: rtl/mux4a2_cond_tx_pkg.sv
// Shared Tx/Rx lane-combiner definitions: lane width and the slot-phase encoding.
// The demux on the Rx side uses the same encodings, so the slot ordering lives here only.
package mux4a2_cond_tx_pkg;

  localparam int unsigned DATA_W = 8;

  // Slot 0 carries lanes 0/2 (capture edge); slot 1 carries the held lanes 1/3.
  typedef enum logic {
    SLOT0 = 1'b0,
    SLOT1 = 1'b1
  } slot_e;

  // Phase advance: the slot alternates on every clk_2f edge.
  function automatic slot_e next_slot(input slot_e s);
    return (s == SLOT0) ? SLOT1 : SLOT0;
  endfunction

endpackage

// File: rtl/mux2a1_cond_tx.sv
// Conditional 2-to-1 time-interleaver for one output lane.
// Ports:
//   clk_2f, reset_L      : clock (2x word rate), async active-low reset
//   sel                  : current slot, shared with the sibling instance
//   valid_a, data_a      : word sent in slot 0 (captured on the sel=SLOT0 edge)
//   valid_b, data_b      : word held on the sel=SLOT0 edge, sent in slot 1
//   valid_out, data_out  : registered output lane; data holds when a slot is invalid
module mux2a1_cond_tx
  import mux4a2_cond_tx_pkg::slot_e;
  import mux4a2_cond_tx_pkg::SLOT0;
#(
  parameter int unsigned DATA_W = mux4a2_cond_tx_pkg::DATA_W
) (
  input  logic              clk_2f,
  input  logic              reset_L,
  input  slot_e             sel,
  input  logic              valid_a,
  input  logic [DATA_W-1:0] data_a,
  input  logic              valid_b,
  input  logic [DATA_W-1:0] data_b,
  output logic              valid_out,
  output logic [DATA_W-1:0] data_out
);

  logic              hold_valid_q, hold_valid_d;
  logic [DATA_W-1:0] hold_data_q,  hold_data_d;
  logic              valid_out_q,  valid_out_d;
  logic [DATA_W-1:0] data_out_q,   data_out_d;

  // Slot selection: slot 0 sends word a and parks word b; slot 1 sends the parked word.
  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    valid_out_d  = 1'b0;
    data_out_d   = data_out_q;

    if (sel == SLOT0) begin
      hold_valid_d = valid_b;
      hold_data_d  = data_b;
      if (valid_a) begin
        valid_out_d = 1'b1;
        data_out_d  = data_a;
      end
    end else begin
      // Inputs are ignored here; only the word parked at the capture edge is used.
      if (hold_valid_q) begin
        valid_out_d = 1'b1;
        data_out_d  = hold_data_q;
      end
    end
  end

  // State registers; reset discards any parked word so it is never emitted.
  always_ff @(posedge clk_2f or negedge reset_L) begin
    if (!reset_L) begin
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
      valid_out_q  <= 1'b0;
      data_out_q   <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
      valid_out_q  <= valid_out_d;
      data_out_q   <= data_out_d;
    end
  end

  assign valid_out = valid_out_q;
  assign data_out  = data_out_q;

endmodule

// File: rtl/mux4a2_cond_tx.sv
// Tx lane combiner: four slow-rate lanes onto two clk_2f-rate lanes.
// Lanes 0/1 interleave onto output lane 0, lanes 2/3 onto output lane 1,
// ordered slot0 (lane 0/2) then slot1 (lane 1/3) so the Rx demux restores the mapping.
// Ports:
//   clk_2f, reset_L           : clock (2x word rate), async active-low reset
//   valid0..3, data_in0..3    : input lanes, stable across a capture edge and the next edge
//   valid_out0/1, data_out0/1 : registered output lanes
module mux4a2_cond_tx
  import mux4a2_cond_tx_pkg::slot_e;
  import mux4a2_cond_tx_pkg::SLOT0;
  import mux4a2_cond_tx_pkg::next_slot;
#(
  parameter int unsigned DATA_W = mux4a2_cond_tx_pkg::DATA_W
) (
  input  logic              clk_2f,
  input  logic              reset_L,
  input  logic              valid0,
  input  logic              valid1,
  input  logic              valid2,
  input  logic              valid3,
  input  logic [DATA_W-1:0] data_in0,
  input  logic [DATA_W-1:0] data_in1,
  input  logic [DATA_W-1:0] data_in2,
  input  logic [DATA_W-1:0] data_in3,
  output logic              valid_out0,
  output logic              valid_out1,
  output logic [DATA_W-1:0] data_out0,
  output logic [DATA_W-1:0] data_out1
);

  slot_e sel_q, sel_d;

  // Shared phase: the first edge after reset release is always a capture (slot 0).
  always_comb begin
    sel_d = next_slot(sel_q);
  end

  always_ff @(posedge clk_2f or negedge reset_L) begin
    if (!reset_L) begin
      sel_q <= SLOT0;
    end else begin
      sel_q <= sel_d;
    end
  end

  // Output lane 0: lane 0 in slot 0, lane 1 in slot 1.
  mux2a1_cond_tx #(
    .DATA_W (DATA_W)
  ) u_lane0 (
    .clk_2f    (clk_2f),
    .reset_L   (reset_L),
    .sel       (sel_q),
    .valid_a   (valid0),
    .data_a    (data_in0),
    .valid_b   (valid1),
    .data_b    (data_in1),
    .valid_out (valid_out0),
    .data_out  (data_out0)
  );

  // Output lane 1: lane 2 in slot 0, lane 3 in slot 1.
  mux2a1_cond_tx #(
    .DATA_W (DATA_W)
  ) u_lane1 (
    .clk_2f    (clk_2f),
    .reset_L   (reset_L),
    .sel       (sel_q),
    .valid_a   (valid2),
    .data_a    (data_in2),
    .valid_b   (valid3),
    .data_b    (data_in3),
    .valid_out (valid_out1),
    .data_out  (data_out1)
  );

endmodule

// File: tb/tb_mux4a2_cond_tx.sv
// Scoreboard bench for mux4a2_cond_tx: stimulus pushes per-cycle expected
// {valid, data} per output lane; a monitor pops and compares every cycle.
module tb_mux4a2_cond_tx;

  localparam int unsigned DATA_W = 8;

  typedef struct packed {
    logic              v;
    logic [DATA_W-1:0] d;
  } exp_t;

  logic              clk_2f;
  logic              reset_L;
  logic              valid0, valid1, valid2, valid3;
  logic [DATA_W-1:0] data_in0, data_in1, data_in2, data_in3;
  logic              valid_out0, valid_out1;
  logic [DATA_W-1:0] data_out0, data_out1;

  int tests  = 0;
  int errors = 0;

  exp_t              exp0_q[$];
  exp_t              exp1_q[$];
  logic [DATA_W-1:0] rx0_q[$];
  logic [DATA_W-1:0] rx1_q[$];
  logic [DATA_W-1:0] last0 = '0;
  logic [DATA_W-1:0] last1 = '0;

  mux4a2_cond_tx #(.DATA_W(DATA_W)) dut (
    .clk_2f     (clk_2f),
    .reset_L    (reset_L),
    .valid0     (valid0),
    .valid1     (valid1),
    .valid2     (valid2),
    .valid3     (valid3),
    .data_in0   (data_in0),
    .data_in1   (data_in1),
    .data_in2   (data_in2),
    .data_in3   (data_in3),
    .valid_out0 (valid_out0),
    .valid_out1 (valid_out1),
    .data_out0  (data_out0),
    .data_out1  (data_out1)
  );

  initial clk_2f = 1'b0;
  always #5 clk_2f = ~clk_2f;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One word period (capture edge + slot-1 edge). Expected values follow the
  // hold rule: an invalid slot repeats the lane's last valid data with valid=0.
  task automatic word(input logic [3:0] v, input logic [7:0] d0, input logic [7:0] d1,
                      input logic [7:0] d2, input logic [7:0] d3, input bit glitch);
    exp_t e;
    @(negedge clk_2f);
    {valid3, valid2, valid1, valid0} = v;
    data_in0 = d0; data_in1 = d1; data_in2 = d2; data_in3 = d3;
    if (v[0]) last0 = d0;
    e.v = v[0]; e.d = last0; exp0_q.push_back(e);
    if (v[1]) last0 = d1;
    e.v = v[1]; e.d = last0; exp0_q.push_back(e);
    if (v[2]) last1 = d2;
    e.v = v[2]; e.d = last1; exp1_q.push_back(e);
    if (v[3]) last1 = d3;
    e.v = v[3]; e.d = last1; exp1_q.push_back(e);
    @(posedge clk_2f);
    if (glitch) begin
      #2;
      data_in1 = 8'h55;
    end
    @(posedge clk_2f);
  endtask

  // Monitor: one comparison per lane per cycle while expectations are pending.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_2f);
      #1;
      if (exp0_q.size() > 0) begin
        e = exp0_q.pop_front();
        check("lane0", {23'd0, valid_out0, data_out0}, {23'd0, e.v, e.d});
        if (valid_out0) rx0_q.push_back(data_out0);
      end
      if (exp1_q.size() > 0) begin
        e = exp1_q.pop_front();
        check("lane1", {23'd0, valid_out1, data_out1}, {23'd0, e.v, e.d});
        if (valid_out1) rx1_q.push_back(data_out1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp_b;
    reset_L = 1'b0;
    {valid3, valid2, valid1, valid0} = 4'h0;
    data_in0 = '0; data_in1 = '0; data_in2 = '0; data_in3 = '0;

    // Reset held for 3 cycles: all outputs zero.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_2f);
      #1;
      check("reset_outputs", {14'd0, valid_out0, valid_out1, data_out0, data_out1}, 32'd0);
    end
    #1 reset_L = 1'b1;

    // All lanes valid.
    word(4'hF, 8'h11, 8'h22, 8'h33, 8'h44, 1'b0);

    // 8-word stream per lane, then demux round-trip of the received order.
    #2;
    rx0_q.delete();
    rx1_q.delete();
    for (int n = 0; n < 8; n++)
      word(4'hF, 8'(8'h00 + n), 8'(8'h10 + n), 8'(8'h20 + n), 8'(8'h30 + n), 1'b0);
    #2;
    check("rx0_count", 32'(rx0_q.size()), 32'd16);
    check("rx1_count", 32'(rx1_q.size()), 32'd16);
    for (int i = 0; i < 16; i++) begin
      exp_b = (i % 2 == 0) ? 8'(i / 2) : 8'(8'h10 + i / 2);
      if (i < rx0_q.size()) check("demux_lane01", 32'(rx0_q[i]), 32'(exp_b));
      exp_b = (i % 2 == 0) ? 8'(8'h20 + i / 2) : 8'(8'h30 + i / 2);
      if (i < rx1_q.size()) check("demux_lane23", 32'(rx1_q[i]), 32'(exp_b));
    end

    // Lane 1 invalid: slot-1 of output lane 0 holds 0x11 with valid low.
    word(4'b1101, 8'h11, 8'hAA, 8'h33, 8'h44, 1'b0);

    // All invalid for 4 cycles: data holds 0x11 / 0x44, valid low.
    word(4'h0, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 1'b0);
    word(4'h0, 8'h01, 8'h02, 8'h03, 8'h04, 1'b0);

    // data_in1 changes to 0x55 after the capture edge; slot 1 still sends 0x62.
    word(4'hF, 8'h61, 8'h62, 8'h63, 8'h64, 1'b1);

    // Reset mid-operation after a capture edge.
    @(negedge clk_2f);
    {valid3, valid2, valid1, valid0} = 4'hF;
    data_in0 = 8'h71; data_in1 = 8'h72; data_in2 = 8'h73; data_in3 = 8'h74;
    exp0_q.push_back(exp_t'({1'b1, 8'h71}));
    exp1_q.push_back(exp_t'({1'b1, 8'h73}));
    @(posedge clk_2f);
    #3;
    exp0_q.delete();
    exp1_q.delete();
    reset_L = 1'b0;
    #1;
    check("async_reset", {14'd0, valid_out0, valid_out1, data_out0, data_out1}, 32'd0);
    last0 = '0;
    last1 = '0;
    @(posedge clk_2f);
    @(posedge clk_2f);
    #1;
    check("reset_hold", {14'd0, valid_out0, valid_out1, data_out0, data_out1}, 32'd0);
    #1 reset_L = 1'b1;

    // Parked 0x72/0x74 must not appear; first edge after release is a capture.
    word(4'b0101, 8'h81, 8'h99, 8'h83, 8'h98, 1'b0);
    word(4'hF, 8'h91, 8'h92, 8'h93, 8'h94, 1'b0);

    @(posedge clk_2f);
    #2;
    check("scoreboard_drained", 32'(exp0_q.size() + exp1_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
